// File: rtl/floo_sa_local_arb.sv
// Local switch-allocation stage for one router input port: picks one VC head per cycle
// (round-robin, credit-masked, starvation escalation) and holds wormhole packets together.
module floo_sa_local_arb #(
    parameter int unsigned NumVC        = 4,
    parameter int unsigned NumPorts     = 5,
    parameter int unsigned VcIdWidth    = NumVC > 1 ? $clog2(NumVC) : 1,
    parameter int unsigned DirWidth     = NumPorts > 1 ? $clog2(NumPorts) : 1,
    parameter bit          CreditAware  = 1'b1,
    parameter int unsigned StarveThresh = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NumVC-1:0]                   vc_head_v_i,
    input  logic [NumVC-1:0][DirWidth-1:0]     vc_head_dir_i,
    input  logic [NumVC-1:0]                   vc_head_last_i,
    input  logic [NumPorts-1:0]                out_ready_i,
    input  logic                               sa_global_gnt_i,
    output logic                               sa_local_v_o,
    output logic [VcIdWidth-1:0]               sa_local_vc_id_o,
    output logic [NumVC-1:0]                   sa_local_vc_id_oh_o,
    output logic [NumPorts-1:0]                sa_local_dir_oh_o,
    output logic                               locked_o
);

    localparam int unsigned   CntW   = StarveThresh > 0 ? $clog2(StarveThresh + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(StarveThresh);

    logic [VcIdWidth-1:0]        ptr_q, ptr_d, lock_vc_q, lock_vc_d;
    logic                        lock_q, lock_d;
    logic [DirWidth-1:0]         lock_dir_q, lock_dir_d;
    logic [NumVC-1:0][CntW-1:0]  cnt_q, cnt_d;

    logic [NumVC-1:0]            elig, starved;
    logic                        sel_v, gnt;
    logic [VcIdWidth-1:0]        sel;
    logic [DirWidth-1:0]         sel_dir;

    // Out-of-range direction codes never have credit.
    function automatic logic dir_ready(input logic [DirWidth-1:0] d,
                                       input logic [NumPorts-1:0] rdy);
        logic r;
        r = 1'b0;
        for (int p = 0; p < NumPorts; p++)
            if (d == DirWidth'(p)) r = rdy[p];
        return r;
    endfunction

    always_comb begin
        elig    = '0;
        starved = '0;
        for (int i = 0; i < NumVC; i++) begin
            elig[i]    = vc_head_v_i[i] & (!CreditAware | dir_ready(vc_head_dir_i[i], out_ready_i));
            starved[i] = elig[i] && (StarveThresh != 0) && (cnt_q[i] == CntMax);
        end
    end

    // Descending scans so the lowest index / nearest-to-ptr candidate wins last.
    always_comb begin
        int idx;
        idx   = 0;
        sel_v = 1'b0;
        sel   = '0;
        if (lock_q) begin
            sel   = lock_vc_q;
            sel_v = vc_head_v_i[lock_vc_q] & (!CreditAware | dir_ready(lock_dir_q, out_ready_i));
        end else if (|starved) begin
            for (int i = NumVC - 1; i >= 0; i--)
                if (starved[i]) begin
                    sel_v = 1'b1;
                    sel   = VcIdWidth'(i);
                end
        end else begin
            for (int off = NumVC - 1; off >= 0; off--) begin
                idx = (int'(ptr_q) + off) % NumVC;
                if (elig[idx]) begin
                    sel_v = 1'b1;
                    sel   = VcIdWidth'(idx);
                end
            end
        end
    end

    assign sel_dir = lock_q ? lock_dir_q : vc_head_dir_i[sel];
    assign gnt     = sa_global_gnt_i & sel_v;

    always_comb begin
        sa_local_v_o        = sel_v;
        sa_local_vc_id_o    = sel_v ? sel : '0;
        sa_local_vc_id_oh_o = '0;
        sa_local_dir_oh_o   = '0;
        if (sel_v) sa_local_vc_id_oh_o[sel] = 1'b1;
        for (int p = 0; p < NumPorts; p++)
            sa_local_dir_oh_o[p] = sel_v && (sel_dir == DirWidth'(p));
        locked_o = lock_q;
    end

    always_comb begin
        ptr_d      = ptr_q;
        lock_d     = lock_q;
        lock_vc_d  = lock_vc_q;
        lock_dir_d = lock_dir_q;
        cnt_d      = cnt_q;
        if (gnt) begin
            if (vc_head_last_i[sel]) begin
                lock_d = 1'b0;
                ptr_d  = VcIdWidth'((int'(sel) + 1) % NumVC);
            end else if (!lock_q) begin
                lock_d     = 1'b1;
                lock_vc_d  = sel;
                lock_dir_d = sel_dir;
            end
        end
        for (int i = 0; i < NumVC; i++) begin
            if ((gnt && sel == VcIdWidth'(i)) || !vc_head_v_i[i])
                cnt_d[i] = '0;
            else if (cnt_q[i] != CntMax)
                cnt_d[i] = cnt_q[i] + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_vc_q  <= '0;
            lock_dir_q <= '0;
            cnt_q      <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lock_vc_q  <= lock_vc_d;
            lock_dir_q <= lock_dir_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_floo_sa_local_arb.sv
// Scenario bench for floo_sa_local_arb (NumVC=4, NumPorts=5, StarveThresh=8).
module tb_floo_sa_local_arb;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       v, last;
    logic [3:0][2:0]  dir;
    logic [4:0]       rdy;
    logic             gnt;
    logic             sa_v, locked;
    logic [1:0]       sa_id;
    logic [3:0]       sa_id_oh;
    logic [4:0]       sa_dir_oh;

    int               n_tests = 0;
    int               n_fail  = 0;
    logic [12:0]      exp_q[$];
    logic [12:0]      e;
    wire  [12:0]      obs = {sa_v, sa_id, sa_id_oh, sa_dir_oh, locked};

    floo_sa_local_arb #(.NumVC(4), .NumPorts(5), .CreditAware(1'b1), .StarveThresh(8)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .vc_head_v_i         (v),
        .vc_head_dir_i       (dir),
        .vc_head_last_i      (last),
        .out_ready_i         (rdy),
        .sa_global_gnt_i     (gnt),
        .sa_local_v_o        (sa_v),
        .sa_local_vc_id_o    (sa_id),
        .sa_local_vc_id_oh_o (sa_id_oh),
        .sa_local_dir_oh_o   (sa_dir_oh),
        .locked_o            (locked)
    );

    always #5 clk = ~clk;

    // Expected output vector {v, id, id_oh, dir_oh, locked}.
    function automatic logic [12:0] mk(bit ev, int id, int d, bit lk);
        logic [3:0] oh;
        logic [4:0] doh;
        logic [1:0] idv;
        oh  = '0;
        doh = '0;
        idv = '0;
        if (ev) begin
            oh[id] = 1'b1;
            doh[d] = 1'b1;
            idv    = 2'(id);
        end
        return {ev, idv, oh, doh, lk};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; v = '0; last = '0; gnt = 1'b0; rdy = '1; dir = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        gnt = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(mk(0, 0, 0, 0));
            #3;
            e = exp_q.pop_front();
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %b want %b", k, obs, e);
            end
            step();
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        v = 4'hf; last = 4'hf; gnt = 1'b1;
        dir = {3'd3, 3'd2, 3'd1, 3'd0};
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(mk(1, k % 4, k % 4, 0));
            #3;
            e = exp_q.pop_front();
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL rr[%0d]: got %b want %b", k, obs, e);
            end
            step();
        end
    endtask

    // Columns: v, last, dir of VC1, exp valid, exp id, exp dir, exp locked
    task automatic test_wormhole();
        int tab [9][7] = '{
            '{4'h1, 4'hf, 2, 1, 0, 0, 0},   // single flit on VC0 -> ptr=1
            '{4'h7, 4'h0, 2, 1, 1, 2, 0},   // VC1 head, lock taken
            '{4'h7, 4'h0, 0, 1, 1, 2, 1},   // locked dir used, not live dir
            '{4'h7, 4'h2, 2, 1, 1, 2, 1},   // VC1 tail -> ptr=2
            '{4'h5, 4'hf, 2, 1, 2, 4, 0},   // ptr=2 picks VC2 over VC0
            '{4'h2, 4'h0, 2, 1, 1, 2, 0},   // second packet head
            '{4'h0, 4'h0, 2, 0, 0, 0, 1},   // bubble keeps lock
            '{4'h2, 4'h2, 2, 1, 1, 2, 1},   // tail
            '{4'h0, 4'h0, 2, 0, 0, 0, 0}
        };
        do_reset();
        gnt = 1'b1;
        for (int k = 0; k < 9; k++) begin
            v    = 4'(tab[k][0]);
            last = 4'(tab[k][1]);
            dir  = {3'd3, 3'd4, 3'(tab[k][2]), 3'd0};
            exp_q.push_back(mk(tab[k][3] != 0, tab[k][4], tab[k][5], tab[k][6] != 0));
            #3;
            e = exp_q.pop_front();
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL worm[%0d]: got %b want %b", k, obs, e);
            end
            step();
        end
    endtask

    // Columns: v, last, ready, gnt, exp valid, exp id, exp dir, exp locked
    task automatic test_credit_mask();
        int tab [7][8] = '{
            '{4'h3, 4'hf, 5'h17, 0, 1, 1, 1, 0},   // VC0 masked by dir3 credit
            '{4'h3, 4'hf, 5'h1f, 0, 1, 0, 3, 0},   // credit back, no grant earlier
            '{4'h1, 4'hf, 5'h17, 0, 0, 0, 0, 0},
            '{4'h1, 4'h0, 5'h1f, 1, 1, 0, 3, 0},   // lock VC0 to dir3
            '{4'h1, 4'h0, 5'h17, 1, 0, 0, 0, 1},   // credit stall keeps lock
            '{4'h1, 4'h1, 5'h1f, 1, 1, 0, 3, 1},
            '{4'h0, 4'h0, 5'h1f, 1, 0, 0, 0, 0}
        };
        do_reset();
        dir = {3'd0, 3'd0, 3'd1, 3'd3};
        for (int k = 0; k < 7; k++) begin
            v    = 4'(tab[k][0]);
            last = 4'(tab[k][1]);
            rdy  = 5'(tab[k][2]);
            gnt  = tab[k][3] != 0;
            exp_q.push_back(mk(tab[k][4] != 0, tab[k][5], tab[k][6], tab[k][7] != 0));
            #3;
            e = exp_q.pop_front();
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL credit[%0d]: got %b want %b", k, obs, e);
            end
            step();
        end
    endtask

    task automatic test_starvation();
        do_reset();
        gnt = 1'b1;
        dir = {3'd3, 3'd4, 3'd1, 3'd0};
        for (int k = 0; k < 12; k++) begin
            if (k < 10) begin
                v    = (k == 9) ? 4'hb : 4'h9;
                last = (k == 9) ? 4'h1 : 4'h0;
                exp_q.push_back(mk(1, 0, 0, k > 0));
            end else begin
                v    = 4'ha;
                last = 4'hf;
                // k=10: VC3 escalates past ptr=1; k=11: its counter is clear, RR gives VC1
                exp_q.push_back(k == 10 ? mk(1, 3, 3, 0) : mk(1, 1, 1, 0));
            end
            #3;
            e = exp_q.pop_front();
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL starve[%0d]: got %b want %b", k, obs, e);
            end
            step();
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        gnt = 1'b1;
        dir = {3'd3, 3'd4, 3'd1, 3'd0};
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: begin v = 4'h2; last = 4'hf; exp_q.push_back(mk(1, 1, 1, 0)); end
                1: begin v = 4'h4; last = 4'h0; exp_q.push_back(mk(1, 2, 4, 0)); end
                2: begin v = 4'h7; rst = 1'b1;  exp_q.push_back(mk(1, 2, 4, 1)); end
                default: begin rst = 1'b0;      exp_q.push_back(mk(1, 0, 0, 0)); end
            endcase
            #3;
            e = exp_q.pop_front();
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL rstmid[%0d]: got %b want %b", k, obs, e);
            end
            step();
        end
    endtask

    initial begin
        rst = 1'b1; v = '0; last = '0; dir = '0; rdy = '1; gnt = 1'b0;
        test_reset();
        test_round_robin();
        test_wormhole();
        test_credit_mask();
        test_starvation();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
